// File: rtl/pulsador_pkg.sv
// Shared definitions for the pushbutton debouncer / manual-clock pulse stretcher.
package pulsador_pkg;

  // 20 ms debounce and 50 ms output pulse at a 50 MHz clock
  localparam int DB_CYCLES_DEF    = 1000000;
  localparam int PULSE_CYCLES_DEF = 2500000;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_PRESSED   = 2'd2,
    S_REL_CHK   = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/debounce_pulsador.sv
// Pushbutton debouncer: confirms level changes after DB_CYCLES stable samples,
// emits a one-cycle press strobe and a PULSE_CYCLES-wide stretched pulse.
module debounce_pulsador
  import pulsador_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic pulsa,
  output logic evento,
  output logic estable
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = $clog2(PULSE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]  PULSE_LAST = PW'(PULSE_CYCLES);

  logic           sb;
  state_t         state_q, state_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [PW-1:0]  p_cnt_q;
  logic           evento_q, estable_q, pulsa_q;
  logic           press_ok;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (boton),
    .q_o   (sb)
  );

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sb) begin
          state_d  = S_PRESS_CHK;
          db_cnt_d = DBW'(1);
        end
      end
      S_PRESS_CHK: begin
        if (!sb) begin
          state_d  = S_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_PRESSED;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      S_PRESSED: begin
        if (!sb) begin
          state_d  = S_REL_CHK;
          db_cnt_d = DBW'(1);
        end
      end
      S_REL_CHK: begin
        if (sb) begin
          state_d  = S_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // Only a confirmed press counts; falling back from S_REL_CHK is not a new press.
  assign press_ok = (state_q == S_PRESS_CHK) && (state_d == S_PRESSED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      db_cnt_q  <= '0;
      evento_q  <= 1'b0;
      estable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      evento_q  <= press_ok;
      estable_q <= (state_d == S_PRESSED) || (state_d == S_REL_CHK);
    end
  end

  // Stretcher is non-retriggerable: a press while the pulse runs is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulsa_q <= 1'b0;
      p_cnt_q <= '0;
    end else if (pulsa_q) begin
      if (p_cnt_q == PULSE_LAST) begin
        pulsa_q <= 1'b0;
        p_cnt_q <= '0;
      end else begin
        p_cnt_q <= p_cnt_q + PW'(1);
      end
    end else if (press_ok) begin
      pulsa_q <= 1'b1;
      p_cnt_q <= PW'(1);
    end
  end

  assign pulsa   = pulsa_q;
  assign evento  = evento_q;
  assign estable = estable_q;

endmodule

// File: tb/tb_debounce_pulsador.sv
// Scoreboard bench: stimulus queues expected strobe times and pulse windows,
// a negedge monitor pops and compares them as the two DUT instances respond.
module tb_debounce_pulsador;

  typedef struct {
    int st;
    int len;
  } pexp_t;

  logic clk;
  logic reset;
  logic boton;
  logic pulsa0, evento0, estable0;
  logic pulsa1, evento1, estable1;

  int cyc;
  int total;
  int bad;

  int    ev0_q[$];
  int    ev1_q[$];
  pexp_t pl0_q[$];
  pexp_t pl1_q[$];

  // Short-pulse instance matches the reference timing.
  debounce_pulsador #(.DB_CYCLES(4), .PULSE_CYCLES(6)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .boton   (boton),
    .pulsa   (pulsa0),
    .evento  (evento0),
    .estable (estable0)
  );

  // Long-pulse instance lets a full release/re-press land inside one pulse.
  debounce_pulsador #(.DB_CYCLES(4), .PULSE_CYCLES(12)) u_dut_long (
    .clk     (clk),
    .reset   (reset),
    .boton   (boton),
    .pulsa   (pulsa1),
    .evento  (evento1),
    .estable (estable1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_ev(input int c);
    ev0_q.push_back(c);
    ev1_q.push_back(c);
  endtask

  task automatic exp_pulse(input int c, input int l0, input int l1);
    pexp_t p;
    p.st = c;
    if (l0 > 0) begin p.len = l0; pl0_q.push_back(p); end
    if (l1 > 0) begin p.len = l1; pl1_q.push_back(p); end
  endtask

  // Monitor
  initial begin
    int    st0, st1;
    bit    run0, run1;
    pexp_t pe;
    run0 = 0;
    run1 = 0;
    st0  = 0;
    st1  = 0;
    forever begin
      @(negedge clk);
      if (evento0 === 1'b1) begin
        if (ev0_q.size() == 0) chk("evento0_unexpected", cyc, -1);
        else chk("evento0_time", cyc, ev0_q.pop_front());
      end
      if (evento1 === 1'b1) begin
        if (ev1_q.size() == 0) chk("evento1_unexpected", cyc, -1);
        else chk("evento1_time", cyc, ev1_q.pop_front());
      end
      if (pulsa0 === 1'b1 && !run0) begin
        run0 = 1;
        st0  = cyc;
      end else if (pulsa0 !== 1'b1 && run0) begin
        run0 = 0;
        if (pl0_q.size() == 0) chk("pulsa0_unexpected", st0, -1);
        else begin
          pe = pl0_q.pop_front();
          chk("pulsa0_start", st0, pe.st);
          chk("pulsa0_width", cyc - st0, pe.len);
        end
      end
      if (pulsa1 === 1'b1 && !run1) begin
        run1 = 1;
        st1  = cyc;
      end else if (pulsa1 !== 1'b1 && run1) begin
        run1 = 0;
        if (pl1_q.size() == 0) chk("pulsa1_unexpected", st1, -1);
        else begin
          pe = pl1_q.pop_front();
          chk("pulsa1_start", st1, pe.st);
          chk("pulsa1_width", cyc - st1, pe.len);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int k, p;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    boton = 1'b0;
    tick(3);
    chk("rst_pulsa",   int'(pulsa0),   0);
    chk("rst_evento",  int'(evento0),  0);
    chk("rst_estable", int'(estable0), 0);
    chk("rst_pulsa_l", int'(pulsa1),   0);
    reset = 1'b0;
    tick(4);

    // Clean press
    k = cyc;
    boton = 1'b1;
    exp_ev(k + 6);
    exp_pulse(k + 6, 6, 12);
    tick(5);
    chk("press_estable_pending", int'(estable0), 0);
    tick(1);
    chk("press_estable", int'(estable0), 1);
    tick(14);
    boton = 1'b0;
    tick(10);
    chk("release_estable", int'(estable0), 0);
    tick(30);

    // Bounce on press
    boton = 1'b1; tick(1);
    boton = 1'b0; tick(1);
    boton = 1'b1; tick(1);
    boton = 1'b0; tick(1);
    k = cyc;
    boton = 1'b1;
    exp_ev(k + 6);
    exp_pulse(k + 6, 6, 12);
    tick(20);
    chk("bounce_estable", int'(estable0), 1);
    boton = 1'b0;
    tick(30);

    // Three-cycle glitch never confirms
    boton = 1'b1;
    tick(3);
    boton = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_estable", int'(estable0), 0);
    end
    chk("glitch_pulsa", int'(pulsa0), 0);
    tick(20);

    // Release glitch while pressed
    k = cyc;
    boton = 1'b1;
    exp_ev(k + 6);
    exp_pulse(k + 6, 6, 12);
    tick(14);
    boton = 1'b0;
    tick(2);
    boton = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("relglitch_estable", int'(estable0), 1);
    end
    boton = 1'b0;
    tick(10);
    chk("relglitch_release", int'(estable0), 0);
    tick(30);

    // Rapid re-press: second press lands inside the long pulse
    k = cyc;
    boton = 1'b1;
    exp_ev(k + 6);
    exp_ev(k + 14);
    exp_pulse(k + 6, 6, 12);
    exp_pulse(k + 14, 6, 0);
    tick(4);
    boton = 1'b0;
    tick(4);
    boton = 1'b1;
    tick(2);
    chk("repress_release_confirmed", int'(estable0), 0);
    chk("repress_long_pulse_high", int'(pulsa1), 1);
    tick(20);
    boton = 1'b0;
    tick(30);

    // Reset at pulse cycle 3 with the button still held
    k = cyc;
    p = k + 6;
    boton = 1'b1;
    exp_ev(p);
    exp_pulse(p, 3, 3);
    tick(p + 2 - cyc);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_pulsa",   int'(pulsa0),   0);
    chk("rst_mid_estable", int'(estable0), 0);
    chk("rst_mid_pulsa_l", int'(pulsa1),   0);
    reset = 1'b0;
    exp_ev(cyc + 6);
    exp_pulse(cyc + 6, 6, 12);
    tick(25);
    chk("after_rst_estable", int'(estable0), 1);
    boton = 1'b0;
    tick(30);

    chk("ev0_queue_left", ev0_q.size(), 0);
    chk("ev1_queue_left", ev1_q.size(), 0);
    chk("pl0_queue_left", pl0_q.size(), 0);
    chk("pl1_queue_left", pl1_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
